if_prefetch: RTL and testbench

Instruction fetch stage with a prefetch queue, sitting directly upstream of the `mips` datapath/controller pair. It owns the fetch PC, issues single-outstanding read requests to a variable-latency instruction memory, buffers returned words with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. Branch/jump redirects from the datapath flush the queue and restart fetch at the target.

---
 rtl/if_prefetch.sv | 145 ++++++++++++++
 tb/tb_if_prefetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction fetch stage: single-outstanding requests to a variable-latency
// instruction memory, a small {pc, word} queue toward decode, and redirect flush.
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              instruction,
  output logic [31:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [1:0]               fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [63:0]     mem [DEPTH];

  logic            push;
  logic            pop;
  logic [CW-1:0]   count_next;
  logic [31:0]     target;
  logic [31:0]     pc_plus4;

  // Handshake: a head word transfers to decode on any edge where
  // inst_valid && inst_ready; a redirect in that cycle voids the transfer.
  assign inst_valid  = (count != '0);
  assign pop         = inst_valid && inst_ready && !redirect;
  // In WAIT the outstanding request address always equals fetch_pc.
  assign push        = (state == WAIT) && imem_ack && !redirect;
  assign count_next  = count + CW'(push) - CW'(pop);
  assign target      = {redirect_pc[31:2], 2'b00};
  assign pc_plus4    = fetch_pc + 32'd4;

  assign instruction = inst_valid ? mem[rd_ptr][31:0]  : 32'h0;
  assign inst_pc     = inst_valid ? mem[rd_ptr][63:32] : 32'h0;
  assign fifo_count  = count;
  assign fsm_state   = state;

  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem[wr_ptr] <= {fetch_pc, imem_rdata};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (redirect) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= target;
      case (state)
        IDLE: begin
          state     <= WAIT;
          imem_req  <= 1'b1;
          imem_addr <= target;
        end
        WAIT, DROP: begin
          // An ack this cycle retires the stale request; otherwise keep
          // holding it and discard its data when it finally returns.
          if (imem_ack) begin
            state     <= WAIT;
            imem_addr <= target;
          end else begin
            state <= DROP;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (count_next < FULL) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc <= pc_plus4;
            // The slot for the next request must be free before it issues.
            if (count_next < FULL) begin
              imem_addr <= pc_plus4;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            if (count_next < FULL) begin
              state     <= WAIT;
              imem_addr <= fetch_pc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a vector table for per-cycle behaviour plus
// hand-written sequences for backpressure, memory latency, reset and IDLE redirect.
module tb_if_prefetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc),
    .fifo_count(fifo_count), .fsm_state(fsm_state)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic redir, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic [2:0] e_cnt);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_inst = e_inst; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req,    32'h0);
    check({tag, "_addr"},  imem_addr,   32'h0);
    check({tag, "_valid"}, inst_valid,  32'h0);
    check({tag, "_inst"},  instruction, 32'h0);
    check({tag, "_pc"},    inst_pc,     32'h0);
    check({tag, "_cnt"},   fifo_count,  32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    step();
    step();
  endtask

  // Zero-wait memory with decode stalled until the queue fills.
  task automatic fill_full(input string tag);
    int acks;
    acks = 0;
    inst_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      imem_ack   = imem_req;
      imem_rdata = 32'hC000_0000 | imem_addr;
      step();
      if (imem_ack) acks++;
    end
    imem_ack = 1'b0;
    check({tag, "_acks"}, acks, 32'd4);
    check({tag, "_cnt"}, fifo_count, 32'd4);
    check({tag, "_req"}, imem_req, 32'd0);
  endtask

  initial begin
    // Main table; rows follow on directly from reset release.
    vecs[0]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         0);
    vecs[1]  = mk(1, 32'hC000_0000, 0, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'hC000_0000, 1);
    vecs[2]  = mk(1, 32'hC000_0004, 1, 0, 32'h0,         1, 32'h8,         1, 32'h4,         32'hC000_0004, 1);
    vecs[3]  = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         0, 32'h0,         32'h0,         0);
    vecs[4]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         0, 32'h0,         32'h0,         0);
    vecs[5]  = mk(1, 32'hC000_0008, 0, 0, 32'h0,         1, 32'hC,         1, 32'h8,         32'hC000_0008, 1);
    vecs[6]  = mk(0, 32'h0,         1, 1, 32'h0000_0103, 1, 32'hC,         0, 32'h0,         32'h0,         0);
    vecs[7]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'hC,         0, 32'h0,         32'h0,         0);
    vecs[8]  = mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0,         0);
    vecs[9]  = mk(1, 32'hC000_0100, 0, 0, 32'h0,         1, 32'h104,       1, 32'h100,       32'hC000_0100, 1);
    vecs[10] = mk(1, 32'hC000_0104, 1, 1, 32'h200,       1, 32'h200,       0, 32'h0,         32'h0,         0);
    vecs[11] = mk(0, 32'h0,         0, 1, 32'h302,       1, 32'h200,       0, 32'h0,         32'h0,         0);
    vecs[12] = mk(0, 32'h0,         0, 1, 32'h400,       1, 32'h200,       0, 32'h0,         32'h0,         0);
    vecs[13] = mk(1, 32'hBAD0_0000, 0, 1, 32'h500,       1, 32'h500,       0, 32'h0,         32'h0,         0);
    vecs[14] = mk(1, 32'hC000_0500, 0, 0, 32'h0,         1, 32'h504,       1, 32'h500,       32'hC000_0500, 1);
    vecs[15] = mk(1, 32'hC000_0504, 1, 0, 32'h0,         1, 32'h508,       1, 32'h504,       32'hC000_0504, 1);
    vecs[16] = mk(0, 32'h0,         0, 1, 32'hFFFF_FFFF, 1, 32'h508,       0, 32'h0,         32'h0,         0);
    vecs[17] = mk(1, 32'hBAD0_0001, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0);
    vecs[18] = mk(1, 32'h1234_5678, 0, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC, 32'h1234_5678, 1);
    vecs[19] = mk(1, 32'hC000_0000, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'hC000_0000, 1);

    do_reset();
    check_reset_outputs("reset");

    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].rdata;
      inst_ready  = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      step();
      check($sformatf("row%0d_req", i),   imem_req,    vecs[i].e_req);
      check($sformatf("row%0d_addr", i),  imem_addr,   vecs[i].e_addr);
      check($sformatf("row%0d_valid", i), inst_valid,  vecs[i].e_valid);
      check($sformatf("row%0d_pc", i),    inst_pc,     vecs[i].e_pc);
      check($sformatf("row%0d_inst", i),  instruction, vecs[i].e_inst);
      check($sformatf("row%0d_cnt", i),   fifo_count,  vecs[i].e_cnt);
    end

    // Second entry queued, then reset lands mid-WAIT with a late ack present.
    drive_idle();
    imem_ack = 1'b1; imem_rdata = 32'hC000_0004;
    step();
    check("midrst_pre_cnt", fifo_count, 32'd2);
    check("midrst_pre_addr", imem_addr, 32'h8);
    reset = 1'b0;
    step();
    check_reset_outputs("midrst");
    step();
    check_reset_outputs("midrst_hold");
    imem_ack = 1'b0;
    reset = 1'b1;
    step();
    check("restart_req", imem_req, 32'd1);
    check("restart_addr", imem_addr, 32'h0);

    // Backpressure: exactly DEPTH words fetched, then drained in order.
    fill_full("full");
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d_valid", k), inst_valid, 32'd1);
      check($sformatf("drain%0d_pc", k), inst_pc, 32'(4 * k));
      check($sformatf("drain%0d_inst", k), instruction, 32'hC000_0000 | 32'(4 * k));
      imem_ack   = imem_req;
      imem_rdata = 32'hC000_0000 | imem_addr;
      step();
      if (k == 0) begin
        check("resume_req", imem_req, 32'd1);
        check("resume_addr", imem_addr, 32'h10);
      end
    end

    // Redirect while IDLE with a full queue.
    do_reset();
    reset = 1'b1;
    step();
    fill_full("full2");
    redirect = 1'b1; redirect_pc = 32'h0000_0802; inst_ready = 1'b1;
    step();
    redirect = 1'b0; inst_ready = 1'b0;
    check("idle_redir_valid", inst_valid, 32'd0);
    check("idle_redir_cnt", fifo_count, 32'd0);
    check("idle_redir_req", imem_req, 32'd1);
    check("idle_redir_addr", imem_addr, 32'h800);

    // Three-cycle memory latency with decode always ready.
    begin
      int wait_cnt;
      int acks;
      int pops;
      logic [31:0] held;
      do_reset();
      reset = 1'b1;
      inst_ready = 1'b1;
      step();
      wait_cnt = 0; acks = 0; pops = 0; held = 32'h0;
      for (int c = 0; c < 12; c++) begin
        if (inst_valid) begin
          check($sformatf("lat_pop%0d_pc", pops), inst_pc, 32'(4 * pops));
          pops++;
        end
        if (imem_req) begin
          wait_cnt++;
          if (wait_cnt == 1) held = imem_addr;
          else check($sformatf("lat_hold%0d", c), imem_addr, held);
        end
        imem_ack = (wait_cnt == 3);
        imem_rdata = 32'hC000_0000 | imem_addr;
        if (imem_ack) begin
          check($sformatf("lat_ack%0d_addr", acks), imem_addr, 32'(4 * acks));
          acks++;
          wait_cnt = 0;
        end
        step();
      end
      imem_ack = 1'b0;
      check("lat_acks", acks, 32'd4);
      check("lat_pops", pops, 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
